// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch port and a load/store port onto one memory port.
// Each requester has a one-deep capture buffer; dmem wins ties until imem has waited STARVE_MAX grants.
module mem_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] imem_addr,
  input  logic [3:0]  imem_rmask,
  output logic [31:0] imem_rdata,
  output logic        imem_resp,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_rmask,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D} state_t;

  state_t        state_q, state_d;
  logic          ipend_q, dpend_q;
  logic [31:0]   iaddr_q, daddr_q, dwdata_q;
  logic [3:0]    irmask_q, drmask_q, dwmask_q;
  logic [SW-1:0] starve_q, starve_d;
  logic          grant_i, grant_d, done_i, done_d, cap_i, cap_d;

  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state_q == IDLE) begin
      if (ipend_q && dpend_q) begin
        if (starve_q == SW'(STARVE_MAX)) grant_i = 1'b1;
        else                             grant_d = 1'b1;
      end else begin
        grant_i = ipend_q;
        grant_d = dpend_q;
      end
    end
  end

  assign done_i = (state_q == WAIT_I) && mem_resp;
  assign done_d = (state_q == WAIT_D) && mem_resp;
  // A request landing in its own completion cycle refills the buffer.
  assign cap_i  = (imem_rmask != 4'h0) && (!ipend_q || done_i);
  assign cap_d  = ((dmem_rmask | dmem_wmask) != 4'h0) && (!dpend_q || done_d);

  always_comb begin
    starve_d = starve_q;
    if (!ipend_q || grant_i) starve_d = '0;
    else if (grant_d && (starve_q != SW'(STARVE_MAX))) starve_d = starve_q + 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    mem_addr   = 32'h0;
    mem_rmask  = 4'h0;
    mem_wmask  = 4'h0;
    mem_wdata  = 32'h0;
    imem_resp  = 1'b0;
    imem_rdata = 32'h0;
    dmem_resp  = 1'b0;
    dmem_rdata = 32'h0;
    case (state_q)
      IDLE: begin
        if (grant_i) begin
          mem_addr  = iaddr_q & ~32'h3;
          mem_rmask = irmask_q;
          state_d   = WAIT_I;
        end else if (grant_d) begin
          mem_addr  = daddr_q & ~32'h3;
          mem_rmask = drmask_q;
          mem_wmask = dwmask_q;
          mem_wdata = dwdata_q;
          state_d   = WAIT_D;
        end
      end
      WAIT_I: begin
        if (mem_resp) begin
          imem_resp  = 1'b1;
          imem_rdata = mem_rdata;
          state_d    = IDLE;
        end
      end
      WAIT_D: begin
        if (mem_resp) begin
          dmem_resp  = 1'b1;
          dmem_rdata = mem_rdata;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      starve_q <= '0;
      ipend_q  <= 1'b0;
      iaddr_q  <= 32'h0;
      irmask_q <= 4'h0;
      dpend_q  <= 1'b0;
      daddr_q  <= 32'h0;
      drmask_q <= 4'h0;
      dwmask_q <= 4'h0;
      dwdata_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      if (cap_i) begin
        ipend_q  <= 1'b1;
        iaddr_q  <= imem_addr;
        irmask_q <= imem_rmask;
      end else if (done_i) begin
        ipend_q <= 1'b0;
      end
      if (cap_d) begin
        dpend_q  <= 1'b1;
        daddr_q  <= dmem_addr;
        drmask_q <= dmem_rmask;
        dwmask_q <= dmem_wmask;
        dwdata_q <= dmem_wdata;
      end else if (done_d) begin
        dpend_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized run
// compared against a transaction-level model built from queues.
module tb_mem_arbiter;
  localparam int SMAX = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  imem_rmask, dmem_rmask, dmem_wmask;
  logic        imem_resp, dmem_resp;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_rmask, mem_wmask;
  logic        mem_resp;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } req_t;

  mem_arbiter #(.STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr), .imem_rmask(imem_rmask), .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .mem_addr(mem_addr), .mem_rmask(mem_rmask), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  function automatic logic [137:0] outs();
    return {mem_addr, mem_rmask, mem_wmask, mem_wdata, imem_resp, imem_rdata, dmem_resp, dmem_rdata};
  endfunction

  task automatic clear_inputs();
    imem_addr = 32'h0; imem_rmask = 4'h0;
    dmem_addr = 32'h0; dmem_rmask = 4'h0; dmem_wmask = 4'h0; dmem_wdata = 32'h0;
    mem_rdata = 32'h0; mem_resp = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    mem_resp = 1'b1;
    repeat (8) tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    imem_rmask = 4'hF; imem_addr = 32'h0000_0010; dmem_wmask = 4'hF; dmem_rmask = 4'hF;
    mem_resp = 1'b1; mem_rdata = 32'h1234_5678;
    #2;
    checks++;
    if (outs() !== '0) begin
      errors++;
      $display("FAIL reset_async: got %h want 0", outs());
    end
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (outs() !== '0) begin
      errors++;
      $display("FAIL reset_clocked: got %h want 0", outs());
    end
    @(negedge clk);
    rst_n = 1'b1;
    clear_inputs();
    imem_rmask = 4'hF; imem_addr = 32'h0000_0100;
    tick();
    clear_inputs();
    @(negedge clk);
    checks++;
    if (mem_rmask !== 4'hF || mem_addr !== 32'h0000_0100) begin
      errors++;
      $display("FAIL first_capture: got addr=%h rmask=%h want addr=00000100 rmask=f", mem_addr, mem_rmask);
    end
    tick();
    mem_resp = 1'b1; mem_rdata = 32'hA5A5_0001;
    @(negedge clk);
    checks++;
    if (imem_resp !== 1'b1 || imem_rdata !== 32'hA5A5_0001) begin
      errors++;
      $display("FAIL first_resp: got resp=%b data=%h want 1 a5a50001", imem_resp, imem_rdata);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_lone_fetch();
    imem_rmask = 4'hF; imem_addr = 32'h1000_0006;
    @(negedge clk);
    checks++;
    if (mem_rmask !== 4'h0 || imem_resp !== 1'b0) begin
      errors++;
      $display("FAIL lone_req_cycle: got rmask=%h resp=%b want 0 0", mem_rmask, imem_resp);
    end
    tick();
    clear_inputs();
    @(negedge clk);
    checks++;
    if (mem_addr !== 32'h1000_0004 || mem_rmask !== 4'hF || mem_wmask !== 4'h0 || mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL lone_issue: got addr=%h rmask=%h wmask=%h wdata=%h want 10000004 f 0 0",
               mem_addr, mem_rmask, mem_wmask, mem_wdata);
    end
    tick();
    mem_resp = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if (imem_resp !== 1'b1 || imem_rdata !== 32'hDEAD_BEEF || mem_rmask !== 4'h0 || dmem_resp !== 1'b0) begin
      errors++;
      $display("FAIL lone_resp: got resp=%b data=%h rmask=%h dresp=%b want 1 deadbeef 0 0",
               imem_resp, imem_rdata, mem_rmask, dmem_resp);
    end
    tick();
    clear_inputs();
    @(negedge clk);
    checks++;
    if (imem_resp !== 1'b0 || imem_rdata !== 32'h0 || mem_rmask !== 4'h0) begin
      errors++;
      $display("FAIL lone_after: got resp=%b data=%h rmask=%h want 0 0 0", imem_resp, imem_rdata, mem_rmask);
    end
  endtask

  task automatic test_simultaneous();
    tick();
    imem_rmask = 4'hF; imem_addr = 32'h0000_2000;
    dmem_wmask = 4'b0100; dmem_addr = 32'h0000_3002; dmem_wdata = 32'h00AB_0000;
    tick();
    clear_inputs();
    @(negedge clk);
    checks++;
    if (mem_addr !== 32'h0000_3000 || mem_wmask !== 4'b0100 || mem_rmask !== 4'h0 || mem_wdata !== 32'h00AB_0000) begin
      errors++;
      $display("FAIL simul_dmem_first: got addr=%h wmask=%h rmask=%h wdata=%h want 00003000 4 0 00ab0000",
               mem_addr, mem_wmask, mem_rmask, mem_wdata);
    end
    tick();
    mem_resp = 1'b1; mem_rdata = 32'h0;
    @(negedge clk);
    checks++;
    if (dmem_resp !== 1'b1 || imem_resp !== 1'b0) begin
      errors++;
      $display("FAIL simul_dmem_resp: got dresp=%b iresp=%b want 1 0", dmem_resp, imem_resp);
    end
    tick();
    clear_inputs();
    @(negedge clk);
    checks++;
    if (mem_addr !== 32'h0000_2000 || mem_rmask !== 4'hF || mem_wmask !== 4'h0) begin
      errors++;
      $display("FAIL simul_imem_next: got addr=%h rmask=%h wmask=%h want 00002000 f 0", mem_addr, mem_rmask, mem_wmask);
    end
    tick();
    mem_resp = 1'b1; mem_rdata = 32'hCAFE_0002;
    @(negedge clk);
    checks++;
    if (imem_resp !== 1'b1 || imem_rdata !== 32'hCAFE_0002) begin
      errors++;
      $display("FAIL simul_imem_resp: got resp=%b data=%h want 1 cafe0002", imem_resp, imem_rdata);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_starvation();
    logic is_i;
    imem_rmask = 4'hF; imem_addr = 32'h0000_4000;
    dmem_rmask = 4'hF; dmem_addr = 32'h0000_5000;
    tick();
    clear_inputs();
    for (int g = 0; g < 2 * (SMAX + 1); g++) begin
      @(negedge clk);
      is_i = (mem_addr == 32'h0000_4000);
      checks++;
      if (mem_rmask !== 4'hF || is_i !== ((g % (SMAX + 1)) == SMAX)) begin
        errors++;
        $display("FAIL starve_grant%0d: got addr=%h rmask=%h want imem=%0d", g, mem_addr, mem_rmask,
                 ((g % (SMAX + 1)) == SMAX));
      end
      tick();
      mem_resp = 1'b1; mem_rdata = 32'(g);
      if (!is_i) begin
        dmem_rmask = 4'hF; dmem_addr = 32'h0000_5000;
      end else if (g == SMAX) begin
        imem_rmask = 4'hF; imem_addr = 32'h0000_4000;
      end
      @(negedge clk);
      checks++;
      if ((is_i ? imem_resp : dmem_resp) !== 1'b1) begin
        errors++;
        $display("FAIL starve_resp%0d: got iresp=%b dresp=%b want owner resp 1", g, imem_resp, dmem_resp);
      end
      tick();
      clear_inputs();
    end
    drain();
  endtask

  task automatic test_back_to_back();
    imem_rmask = 4'hF; imem_addr = 32'h0000_0A00;
    tick();
    clear_inputs();
    tick();
    mem_resp = 1'b1; mem_rdata = 32'h0000_00A0;
    imem_rmask = 4'h3; imem_addr = 32'h0000_0A05;
    @(negedge clk);
    checks++;
    if (imem_resp !== 1'b1 || imem_rdata !== 32'h0000_00A0) begin
      errors++;
      $display("FAIL b2b_first_resp: got resp=%b data=%h want 1 000000a0", imem_resp, imem_rdata);
    end
    tick();
    clear_inputs();
    @(negedge clk);
    checks++;
    if (mem_addr !== 32'h0000_0A04 || mem_rmask !== 4'h3) begin
      errors++;
      $display("FAIL b2b_reissue: got addr=%h rmask=%h want 00000a04 3", mem_addr, mem_rmask);
    end
    tick();
    mem_resp = 1'b1; mem_rdata = 32'h0000_00A1;
    @(negedge clk);
    checks++;
    if (imem_resp !== 1'b1 || imem_rdata !== 32'h0000_00A1) begin
      errors++;
      $display("FAIL b2b_second_resp: got resp=%b data=%h want 1 000000a1", imem_resp, imem_rdata);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    dmem_wmask = 4'hF; dmem_addr = 32'h0000_6000; dmem_wdata = 32'h5555_AAAA;
    tick();
    clear_inputs();
    tick();
    @(negedge clk);
    rst_n = 1'b0;
    mem_resp = 1'b1; mem_rdata = 32'h7777_7777; imem_rmask = 4'hF; dmem_rmask = 4'hF;
    #1;
    checks++;
    if (outs() !== '0) begin
      errors++;
      $display("FAIL rstmid_async: got %h want 0", outs());
    end
    @(posedge clk);
    #1;
    checks++;
    if (outs() !== '0) begin
      errors++;
      $display("FAIL rstmid_clocked: got %h want 0", outs());
    end
    @(negedge clk);
    rst_n = 1'b1;
    clear_inputs();
    mem_resp = 1'b1; mem_rdata = 32'h7777_7777;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (dmem_resp !== 1'b0 || outs() !== '0) begin
        errors++;
        $display("FAIL rstmid_after%0d: got dresp=%b outs=%h want 0", c, dmem_resp, outs());
      end
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_stall();
    imem_rmask = 4'hF; imem_addr = 32'h0000_7000;
    tick();
    clear_inputs();
    @(negedge clk);
    checks++;
    if (mem_rmask !== 4'hF || mem_addr !== 32'h0000_7000) begin
      errors++;
      $display("FAIL stall_issue: got addr=%h rmask=%h want 00007000 f", mem_addr, mem_rmask);
    end
    tick();
    for (int c = 0; c < 50; c++) begin
      if (c == 10) begin
        dmem_wmask = 4'h3; dmem_addr = 32'h0000_8003; dmem_wdata = 32'h0000_BEEF;
      end
      @(negedge clk);
      checks++;
      if (imem_resp !== 1'b0 || dmem_resp !== 1'b0 || mem_rmask !== 4'h0 || mem_wmask !== 4'h0) begin
        errors++;
        $display("FAIL stall_wait%0d: got iresp=%b dresp=%b rmask=%h wmask=%h want 0", c,
                 imem_resp, dmem_resp, mem_rmask, mem_wmask);
      end
      tick();
      clear_inputs();
    end
    mem_resp = 1'b1; mem_rdata = 32'h1111_2222;
    @(negedge clk);
    checks++;
    if (imem_resp !== 1'b1 || imem_rdata !== 32'h1111_2222) begin
      errors++;
      $display("FAIL stall_resp: got resp=%b data=%h want 1 11112222", imem_resp, imem_rdata);
    end
    tick();
    clear_inputs();
    @(negedge clk);
    checks++;
    if (mem_addr !== 32'h0000_8000 || mem_wmask !== 4'h3 || mem_rmask !== 4'h0 || mem_wdata !== 32'h0000_BEEF) begin
      errors++;
      $display("FAIL stall_dmem_issue: got addr=%h wmask=%h rmask=%h wdata=%h want 00008000 3 0 0000beef",
               mem_addr, mem_wmask, mem_rmask, mem_wdata);
    end
    tick();
    mem_resp = 1'b1; mem_rdata = 32'h0000_0033;
    @(negedge clk);
    checks++;
    if (dmem_resp !== 1'b1 || dmem_rdata !== 32'h0000_0033) begin
      errors++;
      $display("FAIL stall_dmem_resp: got resp=%b data=%h want 1 00000033", dmem_resp, dmem_rdata);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_random();
    req_t        iq[$], dq[$], r;
    int          owner, streak, pick;
    logic [137:0] exp_v;
    logic [31:0] e_addr, e_wdata, e_irdata, e_drdata;
    logic [3:0]  e_rmask, e_wmask;
    logic        e_iresp, e_dresp;
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    owner = 0;
    streak = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      imem_addr  = $urandom;
      imem_rmask = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      dmem_addr  = $urandom;
      dmem_wdata = $urandom;
      dmem_rmask = 4'h0;
      dmem_wmask = 4'h0;
      case ($urandom_range(0, 5))
        0: dmem_rmask = 4'($urandom_range(1, 15));
        1: dmem_wmask = 4'($urandom_range(1, 15));
        2: begin
          dmem_rmask = 4'($urandom_range(1, 15));
          dmem_wmask = 4'($urandom_range(1, 15));
        end
        default: ;
      endcase
      mem_resp  = ($urandom_range(0, 2) == 0);
      mem_rdata = $urandom;

      pick = 0;
      if (owner == 0 && (iq.size() + dq.size()) > 0)
        pick = (dq.size() > 0 && (iq.size() == 0 || streak < SMAX)) ? 2 : 1;
      e_addr = 32'h0; e_rmask = 4'h0; e_wmask = 4'h0; e_wdata = 32'h0;
      e_iresp = 1'b0; e_irdata = 32'h0; e_dresp = 1'b0; e_drdata = 32'h0;
      if (pick == 1) begin
        e_addr = {iq[0].addr[31:2], 2'b00}; e_rmask = iq[0].rmask;
      end else if (pick == 2) begin
        e_addr = {dq[0].addr[31:2], 2'b00}; e_rmask = dq[0].rmask;
        e_wmask = dq[0].wmask; e_wdata = dq[0].wdata;
      end
      if (owner == 1 && mem_resp) begin e_iresp = 1'b1; e_irdata = mem_rdata; end
      if (owner == 2 && mem_resp) begin e_dresp = 1'b1; e_drdata = mem_rdata; end
      exp_v = {e_addr, e_rmask, e_wmask, e_wdata, e_iresp, e_irdata, e_dresp, e_drdata};

      @(negedge clk);
      checks++;
      if (outs() !== exp_v) begin
        errors++;
        $display("FAIL rand_cycle%0d: got %h want %h", cyc, outs(), exp_v);
      end

      if (iq.size() == 0 || pick == 1) streak = 0;
      else if (pick == 2 && streak < SMAX) streak++;
      if (pick != 0) owner = pick;
      else if (owner != 0 && mem_resp) begin
        if (owner == 1) void'(iq.pop_front());
        else            void'(dq.pop_front());
        owner = 0;
      end
      if (imem_rmask != 4'h0 && iq.size() == 0) begin
        r.addr = imem_addr; r.rmask = imem_rmask; r.wmask = 4'h0; r.wdata = 32'h0;
        iq.push_back(r);
      end
      if ((dmem_rmask | dmem_wmask) != 4'h0 && dq.size() == 0) begin
        r.addr = dmem_addr; r.rmask = dmem_rmask; r.wmask = dmem_wmask; r.wdata = dmem_wdata;
        dq.push_back(r);
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_lone_fetch();
    test_simultaneous();
    test_starvation();
    test_back_to_back();
    test_reset_mid();
    test_stall();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
